// File: rtl/scan_reader.sv
// rtl/scan_reader.sv - display scan-out engine: raster timing, frame buffer reads, aligned RGB/de/sync output
// Stage 0 counters drive re/addr; returned pixels and delayed syncs leave two cycles later.
module scan_reader #(
  parameter int H_ACTIVE = 100,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 8,
  parameter int V_ACTIVE = 100,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 4,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        re,
  output logic [19:0] addr,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        vblank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [19:0]   A_LAST = 20'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [19:0]   addr_nxt;
  logic          re_nxt;
  logic          run0, hs0, vs0, fs0;
  logic          de1, hs1, vs1, fs1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Run requests are only honoured while idle or on the last cycle of a frame.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    case (state)
      IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (h_cnt == H_LAST) begin
          h_nxt = '0;
          if (v_cnt == V_LAST) begin
            v_nxt = '0;
            if (!enable) state_nxt = IDLE;
          end else begin
            v_nxt = v_cnt + VW'(1);
          end
        end else begin
          h_nxt = h_cnt + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    re_nxt = (state_nxt == RUN) && (h_nxt < H_ACT) && (v_nxt < V_ACT);

    // Address advances after each active pixel, so blanking already holds the next line start.
    if (state_nxt == IDLE || (h_nxt == '0 && v_nxt == '0)) addr_nxt = '0;
    else if (re && addr != A_LAST)                       addr_nxt = addr + 20'd1;
    else                                                  addr_nxt = addr;
  end

  assign run0   = (state == RUN);
  assign hs0    = run0 && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs0    = run0 && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign fs0    = re && (h_cnt == '0) && (v_cnt == '0);
  assign vblank = !run0 || (v_cnt >= V_ACT);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      re          <= 1'b0;
      addr        <= '0;
      de1         <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      fs1         <= 1'b0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      re          <= re_nxt;
      addr        <= addr_nxt;
      de1         <= re;
      hs1         <= hs0;
      vs1         <= vs0;
      fs1         <= fs0;
      de          <= de1;
      frame_start <= fs1;
      hsync       <= hs1 ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs1 ? SYNC_POL : ~SYNC_POL;
      // Blanking cycles emit black, never whatever the read port happens to show.
      r_out       <= de1 ? r_in : '0;
      g_out       <= de1 ? g_in : '0;
      b_out       <= de1 ? b_in : '0;
    end
  end

endmodule

// File: tb/tb_scan_reader.sv
// tb/tb_scan_reader.sv - bench for scan_reader against a raster-position reference model
module tb_scan_reader;

  localparam int H_T = 120;
  localparam int V_T = 108;
  localparam int F   = 12960;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        re, re2;
  logic [19:0] addr, addr2;
  logic [7:0]  r_in, g_in, b_in;
  logic [7:0]  r_out, g_out, b_out, r2, g2, b2;
  logic        de, de2, hsync, hsync2, vsync, vsync2, vblank, vblank2, frame_start, fs2;

  always #5 clk = ~clk;

  scan_reader #(.SYNC_POL(1'b0)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .re(re), .addr(addr),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .de(de), .hsync(hsync), .vsync(vsync), .vblank(vblank), .frame_start(frame_start)
  );

  scan_reader #(.SYNC_POL(1'b1)) u_dut_pol (
    .clk(clk), .reset(reset), .enable(enable), .re(re2), .addr(addr2),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .r_out(r2), .g_out(g2), .b_out(b2),
    .de(de2), .hsync(hsync2), .vsync(vsync2), .vblank(vblank2), .frame_start(fs2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start = 0;
  int stop_c = 1 << 30;
  bit mon_on = 1'b0;
  int seed = 0;
  int e0, e1, e2, f0, f1, f2, n_de, n_re, n_fs;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pix(int i);
    return 24'(i ^ seed);
  endfunction

  function automatic bit run(int c);
    return c >= 0 && c < stop_c;
  endfunction
  function automatic int hp(int c);
    return c % H_T;
  endfunction
  function automatic int vp(int c);
    return (c / H_T) % V_T;
  endfunction
  function automatic int idx(int c);
    return vp(c) * 100 + hp(c);
  endfunction
  function automatic bit act(int c);
    return run(c) && hp(c) < 100 && vp(c) < 100;
  endfunction
  function automatic bit hs(int c);
    return run(c) && hp(c) >= 104 && hp(c) < 112;
  endfunction
  function automatic bit vs(int c);
    return run(c) && vp(c) >= 102 && vp(c) < 104;
  endfunction
  function automatic bit vb(int c);
    return !run(c) || vp(c) >= 100;
  endfunction
  function automatic bit fs(int c);
    return run(c) && (c % F) == 0;
  endfunction

  // Frame buffer: one-cycle read latency, noise whenever not being read.
  always @(posedge clk) begin
    if (re) {r_in, g_in, b_in} <= pix(int'(addr));
    else    {r_in, g_in, b_in} <= 24'($urandom);
  end

  always @(negedge clk) begin : monitor
    int c, d;
    bit x_re, x_de;
    logic [19:0] xa;
    logic [23:0] xp;
    if (mon_on) begin
      c = cyc - start;
      d = c - 2;
      if (re) n_re++;
      if (de) n_de++;
      if (frame_start) n_fs++;
      x_re = act(c);
      xa = x_re ? 20'(idx(c)) : 20'd0;
      if (re !== x_re || re2 !== x_re || vblank !== vb(c) || vblank2 !== vb(c) ||
          (x_re && (addr !== xa || addr2 !== xa)) || (!run(c) && addr !== 20'd0) ||
          addr > 20'd9999) begin
        e0++;
        if (f0 < 0) f0 = c;
      end
      x_de = act(d);
      xp = x_de ? pix(idx(d)) : 24'd0;
      if (de !== x_de || de2 !== x_de || {r_out, g_out, b_out} !== xp || {r2, g2, b2} !== xp ||
          frame_start !== fs(d) || fs2 !== fs(d)) begin
        e1++;
        if (f1 < 0) f1 = c;
      end
      if (hsync !== !hs(d) || vsync !== !vs(d) || hsync2 !== hs(d) || vsync2 !== vs(d)) begin
        e2++;
        if (f2 < 0) f2 = c;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    e0 = 0; e1 = 0; e2 = 0; f0 = -1; f1 = -1; f2 = -1;
    n_de = 0; n_re = 0; n_fs = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    seed = 0;
    repeat (3) step();
    total++; if (re !== 1'b0) begin bad++; $display("FAIL reset_re got=%0b want=0", re); end
    total++; if (addr !== 20'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", addr); end
    total++; if (de !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL reset_de_fs got=%0b%0b want=00", de, frame_start); end
    total++; if ({r_out, g_out, b_out} !== 24'd0) begin bad++; $display("FAIL reset_rgb got=%h want=0", {r_out, g_out, b_out}); end
    total++; if (hsync !== 1'b1 || vsync !== 1'b1) begin bad++; $display("FAIL reset_sync got=%0b%0b want=11", hsync, vsync); end
    total++; if (hsync2 !== 1'b0 || vsync2 !== 1'b0) begin bad++; $display("FAIL reset_sync_pol1 got=%0b%0b want=00", hsync2, vsync2); end
    total++; if (vblank !== 1'b1) begin bad++; $display("FAIL reset_vblank got=%0b want=1", vblank); end
  endtask

  task automatic test_first_frame();
    clear_mon();
    reset = 1'b0;
    step();
    start = cyc;
    stop_c = 1 << 30;
    mon_on = 1'b1;
    total++; if (re !== 1'b1 || addr !== 20'd0) begin bad++; $display("FAIL start_re got re=%0b addr=%0d want re=1 addr=0", re, addr); end
    total++; if (de !== 1'b0) begin bad++; $display("FAIL start_de_early got=%0b want=0", de); end
    step();
    step();
    total++; if (de !== 1'b1 || frame_start !== 1'b1) begin bad++; $display("FAIL start_de_fs got de=%0b fs=%0b want 1 1", de, frame_start); end
    while (cyc - start < F - 1) step();
    @(negedge clk);
    #1;
    total++; if (e0 !== 0) begin bad++; $display("FAIL frame_read errors=%0d first_cycle=%0d want 0", e0, f0); end
    total++; if (e1 !== 0) begin bad++; $display("FAIL frame_pixels errors=%0d first_cycle=%0d want 0", e1, f1); end
    total++; if (e2 !== 0) begin bad++; $display("FAIL frame_sync errors=%0d first_cycle=%0d want 0", e2, f2); end
    total++; if (n_re !== 10000) begin bad++; $display("FAIL frame_re_count got=%0d want=10000", n_re); end
    total++; if (n_de !== 10000) begin bad++; $display("FAIL frame_de_count got=%0d want=10000", n_de); end
    total++; if (n_fs !== 1) begin bad++; $display("FAIL frame_start_count got=%0d want=1", n_fs); end
  endtask

  task automatic test_enable_drop();
    int line, last_addr;
    clear_mon();
    line = $urandom_range(30, 70);
    last_addr = -1;
    while (cyc - start < F + line * H_T) step();
    enable = 1'b0;
    stop_c = 2 * F;
    while (cyc - start < 2 * F + 6) begin
      step();
      if (re) last_addr = int'(addr);
    end
    @(negedge clk);
    #1;
    total++; if (last_addr !== 9999) begin bad++; $display("FAIL drop_last_addr got=%0d want=9999", last_addr); end
    total++; if (e0 !== 0 || e1 !== 0 || e2 !== 0) begin bad++; $display("FAIL drop_stream errors=%0d/%0d/%0d first=%0d/%0d/%0d want 0", e0, e1, e2, f0, f1, f2); end
    total++; if (re !== 1'b0 || vblank !== 1'b1 || addr !== 20'd0) begin bad++; $display("FAIL drop_idle got re=%0b vblank=%0b addr=%0d want 0 1 0", re, vblank, addr); end
  endtask

  task automatic test_reset_mid();
    int de_seen;
    mon_on = 1'b0;
    seed = int'($urandom_range(0, 24'hffffff));
    clear_mon();
    enable = 1'b1;
    step();
    start = cyc;
    stop_c = 1 << 30;
    mon_on = 1'b1;
    total++; if (re !== 1'b1 || addr !== 20'd0) begin bad++; $display("FAIL restart got re=%0b addr=%0d want 1 0", re, addr); end
    while (cyc - start < 43 * H_T + 21) step();
    total++; if (re !== 1'b1 || addr !== 20'd4321) begin bad++; $display("FAIL mid_addr got re=%0b addr=%0d want 1 4321", re, addr); end
    total++; if (e0 !== 0 || e1 !== 0 || e2 !== 0) begin bad++; $display("FAIL restart_stream errors=%0d/%0d/%0d first=%0d/%0d/%0d want 0", e0, e1, e2, f0, f1, f2); end
    reset = 1'b1;
    mon_on = 1'b0;
    step();
    total++; if (re !== 1'b0 || de !== 1'b0 || addr !== 20'd0) begin bad++; $display("FAIL midreset_ctl got re=%0b de=%0b addr=%0d want 0 0 0", re, de, addr); end
    total++; if ({r_out, g_out, b_out} !== 24'd0 || frame_start !== 1'b0) begin bad++; $display("FAIL midreset_rgb got=%h fs=%0b want 0 0", {r_out, g_out, b_out}, frame_start); end
    total++; if (hsync !== 1'b1 || vsync !== 1'b1 || hsync2 !== 1'b0 || vblank !== 1'b1) begin bad++; $display("FAIL midreset_sync got h=%0b v=%0b h2=%0b vb=%0b want 1 1 0 1", hsync, vsync, hsync2, vblank); end
    reset = 1'b0;
    enable = 1'b0;
    de_seen = 0;
    repeat (5) begin
      step();
      if (de !== 1'b0 || {r_out, g_out, b_out} !== 24'd0 || re !== 1'b0) de_seen++;
    end
    total++; if (de_seen !== 0) begin bad++; $display("FAIL midreset_flush stale_cycles=%0d want 0", de_seen); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_first_frame();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
